// File: rtl/segment_value_sampler.sv
// Draws a uniform random value inside a chosen segment using LFSR rejection sampling.
// Optional saturating reject/fallback counters: define SEGMENT_VALUE_SAMPLER_STATS_EN.
module segment_value_sampler #(
  parameter int W         = 8,
  parameter int N         = 4,
  parameter int IDX_W     = 2,
  parameter int MAX_TRIES = 16
) (
  input  logic             in_clock,
  input  logic             in_reset,
  input  logic             in_enable,
  input  logic             in_seed_load,
  input  logic [7:0]       in_seed,
  input  logic             in_segment_valid,
  output logic             out_segment_ready,
  input  logic [1:0]       in_segment_type,
  input  logic [W-1:0]     in_segment_from,
  input  logic [W-1:0]     in_segment_to,
  input  logic [IDX_W-1:0] in_variable_index,
  input  logic [N*W-1:0]   in_current_assignment,
  output logic [N*W-1:0]   out_proposed_assignment,
  output logic [W-1:0]     out_proposed_value,
  output logic             out_fallback,
  output logic             out_valid,
`ifdef SEGMENT_VALUE_SAMPLER_STATS_EN
  output logic [15:0]      out_reject_count,
  output logic [15:0]      out_fallback_count,
`endif
  input  logic             in_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0]  LFSR_RESET = 16'hACE1;
  localparam logic [15:0]  LFSR_TAPS  = 16'hB400;
  localparam logic [W-1:0] MIN_VAL    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_VAL    = {1'b0, {(W-1){1'b1}}};
  localparam logic [7:0]   LAST_TRY   = 8'(MAX_TRIES - 1);

  state_t           state_r, stateNext_s;
  logic [15:0]      lfsr_r, lfsrNext_s, seedWord_s;
  logic [7:0]       tryCnt_r;
  logic [W-1:0]     from_r, to_r;
  logic [IDX_W-1:0] idx_r;
  logic [N*W-1:0]   curAssign_r, newAssign_s;
  logic [W:0]       span_s, mask_s, rVal_s;
  logic [W-1:0]     slotVal_s, resultVal_s;
  logic             empty_s, accept_s, lastTry_s, attempt_s, capture_s;
  logic             finish_s, reject_s, resultFb_s;

  // Smallest all-ones mask covering v: OR every right shift of v into itself.
  function automatic logic [W:0] smearMask(input logic [W:0] v);
    logic [W:0] m;
    m = v;
    for (int k = 1; k <= W; k++) begin
      m = m | (v >> k);
    end
    return m;
  endfunction

  // Segment arithmetic and the per-attempt accept/fallback decision.
  always_comb begin
    span_s      = {to_r[W-1], to_r} - {from_r[W-1], from_r};
    mask_s      = smearMask(span_s);
    rVal_s      = lfsr_r[W:0] & mask_s;
    empty_s     = ($signed(from_r) > $signed(to_r));
    accept_s    = (rVal_s <= span_s);
    lastTry_s   = (tryCnt_r == LAST_TRY);
    attempt_s   = in_enable && (state_r == SAMPLE);
    capture_s   = in_enable && (state_r == IDLE) && in_segment_valid;
    finish_s    = attempt_s && (empty_s || accept_s || lastTry_s);
    reject_s    = attempt_s && !empty_s && !accept_s;
    slotVal_s   = curAssign_r[int'(idx_r)*W +: W];
    if (empty_s) begin
      resultVal_s = slotVal_s;
      resultFb_s  = 1'b1;
    end else if (accept_s) begin
      resultVal_s = from_r + rVal_s[W-1:0];
      resultFb_s  = 1'b0;
    end else begin
      resultVal_s = from_r + span_s[W:1];
      resultFb_s  = 1'b1;
    end
    newAssign_s = curAssign_r;
    newAssign_s[int'(idx_r)*W +: W] = resultVal_s;
  end

  // LFSR next value: a seed load wins over the Galois step; an all-zero seed would lock up.
  always_comb begin
    seedWord_s = {~in_seed, in_seed};
    if (in_seed_load) begin
      lfsrNext_s = (seedWord_s == 16'h0000) ? 16'h0001 : seedWord_s;
    end else if (attempt_s && !empty_s) begin
      lfsrNext_s = lfsr_r[0] ? ((lfsr_r >> 1) ^ LFSR_TAPS) : (lfsr_r >> 1);
    end else begin
      lfsrNext_s = lfsr_r;
    end
  end

  // Next-state logic.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      IDLE:    if (capture_s) stateNext_s = SAMPLE; else stateNext_s = IDLE;
      SAMPLE:  if (finish_s) stateNext_s = DONE; else stateNext_s = SAMPLE;
      DONE:    if (in_enable && in_ready) stateNext_s = IDLE; else stateNext_s = DONE;
      default: stateNext_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) state_r <= IDLE;
    else           state_r <= stateNext_s;
  end

  // LFSR and retry counter; both freeze while disabled.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      lfsr_r   <= LFSR_RESET;
      tryCnt_r <= 8'd0;
    end else if (in_enable) begin
      lfsr_r <= lfsrNext_s;
      if (capture_s)                 tryCnt_r <= 8'd0;
      else if (reject_s && !finish_s) tryCnt_r <= tryCnt_r + 8'd1;
      else                           tryCnt_r <= tryCnt_r;
    end else begin
      lfsr_r   <= lfsr_r;
      tryCnt_r <= tryCnt_r;
    end
  end

  // Segment capture with open bounds clamped to the representable range.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      from_r      <= {W{1'b0}};
      to_r        <= {W{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      curAssign_r <= {(N*W){1'b0}};
    end else if (capture_s) begin
      from_r      <= in_segment_type[0] ? MIN_VAL : in_segment_from;
      to_r        <= in_segment_type[1] ? MAX_VAL : in_segment_to;
      idx_r       <= in_variable_index;
      curAssign_r <= in_current_assignment;
    end
  end

  // Registered outputs; results load only on the cycle the attempt finishes.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      out_segment_ready       <= 1'b1;
      out_valid               <= 1'b0;
      out_fallback            <= 1'b0;
      out_proposed_value      <= {W{1'b0}};
      out_proposed_assignment <= {(N*W){1'b0}};
    end else if (in_enable) begin
      out_segment_ready <= (stateNext_s == IDLE);
      out_valid         <= (stateNext_s == DONE);
      if (finish_s) begin
        out_fallback            <= resultFb_s;
        out_proposed_value      <= resultVal_s;
        out_proposed_assignment <= newAssign_s;
      end
    end
  end

`ifdef SEGMENT_VALUE_SAMPLER_STATS_EN
  // Saturating statistics, cleared only by reset.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      out_reject_count   <= 16'd0;
      out_fallback_count <= 16'd0;
    end else begin
      if (reject_s && (out_reject_count != 16'hFFFF))
        out_reject_count <= out_reject_count + 16'd1;
      if (finish_s && resultFb_s && (out_fallback_count != 16'hFFFF))
        out_fallback_count <= out_fallback_count + 16'd1;
    end
  end
`endif

endmodule

// File: doc/segment_value_sampler.md
Name: segment_value_sampler

Overview:
- Consumes the chosen segment produced by the segment-selection path: type, from, to.
- Draws a uniformly random integer value inside that segment for the variable being proposed.
- Writes the value into that variable's slot of the current assignment vector and presents the updated vector downstream.
- Rejection sampling over a 16-bit LFSR with a bounded retry count; valid/ready handshakes on both sides.

Parameters:
- W, 8, bit width of one signed integer variable (matches BIT_WIDTH_OF_INTEGER_VARIABLE).
- N, 4, number of integer variables (matches NUMBER_OF_INTEGER_VARIABLES).
- IDX_W, 2, variable index width (matches BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX).
- MAX_TRIES, 16, rejection attempts before fallback; legal range 1..255.

Ports:
- in_clock  input  1  single clock, rising edge.
- in_reset  input  1  asynchronous, active-low reset.
- in_enable  input  1  high = FSM and LFSR advance; low = freeze all state.
- in_seed_load  input  1  synchronous load of LFSR with {~in_seed, in_seed}.
- in_seed  input  8  signed seed.
- in_segment_valid  input  1  segment fields valid.
- out_segment_ready  output  1  block can accept a segment.
- in_segment_type  input  2  00 = [from,to]; 01 = (-inf,to]; 10 = [from,+inf); 11 = unbounded.
- in_segment_from  input  W  signed lower bound.
- in_segment_to  input  W  signed upper bound.
- in_variable_index  input  IDX_W  slot to overwrite.
- in_current_assignment  input  N*W  variable 0 in bits [W-1:0].
- out_proposed_assignment  output  N*W  current assignment with the slot replaced.
- out_proposed_value  output  W  sampled value.
- out_fallback  output  1  value came from fallback, not from an accepted sample.
- out_valid  output  1  outputs valid.
- in_ready  input  1  downstream accepts.

Behaviour:
- Reset (in_reset=0, asynchronous):
  - State = IDLE; all outputs 0 except out_segment_ready=1.
  - LFSR = 16'hACE1; try counter = 0.
  - Reset mid-operation aborts the proposal; no output is produced for it.
- FSM states:
  - IDLE: out_segment_ready=1. On in_segment_valid=1 with in_enable=1, capture type, from, to, index and assignment, then go to SAMPLE.
  - SAMPLE: one attempt per enabled cycle. On accept or fallback, register the outputs and go to DONE.
  - DONE: out_valid=1, outputs held stable. When in_ready=1, go to IDLE; out_valid drops the next cycle.
- Bound clamping at capture:
  - Types 01 and 11: from := -2^(W-1).
  - Types 10 and 11: to := 2^(W-1)-1.
- Span computation:
  - span = to - from, computed in W+1 bits, unsigned.
  - mask = smallest 2^k-1 >= span.
- Attempt:
  - r = LFSR[W:0] & mask; accept if r <= span.
  - value = from + r, truncated to W bits; stays in range.
  - LFSR steps only in SAMPLE: Galois, polynomial x^16+x^14+x^13+x^11+1.
- Fallback:
  - After MAX_TRIES rejections: value = from + (span>>1), out_fallback=1.
- Empty segment (captured from > to):
  - Go to DONE after one SAMPLE cycle.
  - Value = current slot value unchanged, out_fallback=1; LFSR does not step.
- Latency: first-try accept gives out_valid one cycle after the handshake edge; each rejection adds one cycle.
- in_enable=0: state, LFSR and counters hold; out_valid, if high, stays high.
- in_seed_load:
  - Honoured in any state; overrides the step for that cycle.
  - A loaded value of 0 is forced to 16'h0001.
- Simultaneous DONE handshake and a new in_segment_valid: the new segment is not accepted until IDLE (one-cycle bubble).

Optional Feature:
- Macro: SEGMENT_VALUE_SAMPLER_STATS_EN.
- Defined: adds output out_reject_count [15:0] and output out_fallback_count [15:0].
  - Both saturating; cleared by reset only.
  - Reject counter increments on each rejected attempt.
  - Fallback counter increments on each DONE entry with out_fallback=1.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Point segment: type 00, from=to=5, index 2, assignment {4,3,2,1} -> out_valid one cycle after handshake; value 5; assignment slot 2 = 5, other slots unchanged; out_fallback=0.
- Empty segment: type 00, from=7, to=3, slot value 9 -> value 9, out_fallback=1; LFSR unchanged; out_valid after one cycle.
- Range sweep: 1000 proposals, type 00, from=-3, to=3, seed 8'h5A loaded -> every value in [-3,3]; all 7 values hit; out_fallback=0 throughout.
- Unbounded: type 11 -> mask 255, span 255, always first-try accept; value = -128 + LFSR[8:0]&255; latency exactly 1.
- Backpressure: in_ready held 0 for 5 cycles in DONE -> outputs stable; out_segment_ready=0; in_ready=1 returns to IDLE.
- Reset mid-SAMPLE with MAX_TRIES=16 and span=128 -> out_valid=0, out_segment_ready=1 immediately; LFSR = 16'hACE1.
